// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/op-class encodings, immediate formats.
// Imported by decode_stage and regfile_2r1w.
package decode_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_JAL    = 3'd4,
      CLS_JALR   = 3'd5,
      CLS_LUI    = 3'd6,
      CLS_AUIPC  = 3'd7
   } op_class_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   function automatic logic [31:0] gen_imm(input logic [31:0] insn, input imm_fmt_e fmt);
      logic [31:0] imm;
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{21{insn[31]}}, insn[30:20]};
         IMM_S:   imm = {{21{insn[31]}}, insn[30:25], insn[11:7]};
         IMM_B:   imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
         IMM_U:   imm = {insn[31:12], 12'h000};
         IMM_J:   imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // insn[30] selects SUB only for register-register ops; for OP-IMM it is immediate data.
   function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic bit30,
                                              input logic is_op);
      alu_op_e op;
      case (funct3)
         3'b000:  op = (is_op && bit30) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, write-to-read bypass for the same nonzero index.
module regfile_2r1w
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            wen,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wen && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      if (ra1 != '0) rd1 = (wen && (wa == ra1)) ? wd : regs[ra1];
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != '0) rd2 = (wen && (wa == ra2)) ? wd : regs[ra2];
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field decode, immediate generation, register read, one-deep output register.
// Build option: DECODE_ILLEGAL_TRAP_EN raises ex_illegal on unknown opcodes (otherwise they flow as NOPs).
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_insn,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   input  logic            wb_wen,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_alu_op,
   output logic [2:0]      ex_op_class,
   output logic [2:0]      ex_funct3,
   output logic            ex_reg_wen,
   output logic            ex_mem_wen,
   output logic            ex_mem_ren,
   output logic            ex_illegal
);

   logic [6:0] opcode;
   logic [4:0] f_rd, f_rs1, f_rs2;
   logic [2:0] f_funct3;

   alu_op_e    d_alu;
   op_class_e  d_class;
   imm_fmt_e   d_fmt;
   logic       d_reg_wen, d_mem_wen, d_mem_ren, d_unknown, d_illegal;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic       xfer;

   assign opcode   = if_insn[6:0];
   assign f_rd     = if_insn[11:7];
   assign f_funct3 = if_insn[14:12];
   assign f_rs1    = if_insn[19:15];
   assign f_rs2    = if_insn[24:20];

   // Handshake: a bundle moves when valid && ready on the same edge. Upstream: if_ready is
   // high whenever the output register is empty or being drained this cycle. Downstream:
   // ex_* hold while ex_valid && !ex_ready. flush overrides both load and hold.
   assign if_ready = !ex_valid || ex_ready;
   assign xfer     = if_valid && if_ready;

   regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (f_rs1),
      .ra2 (f_rs2),
      .rd1 (rs1_val),
      .rd2 (rs2_val),
      .wen (wb_wen),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   always_comb begin
      d_alu     = ALU_ADD;
      d_class   = CLS_ALU;
      d_fmt     = IMM_NONE;
      d_reg_wen = 1'b0;
      d_mem_wen = 1'b0;
      d_mem_ren = 1'b0;
      d_unknown = 1'b0;
      case (opcode)
         OPC_OP: begin
            d_alu     = alu_from_funct(f_funct3, if_insn[30], 1'b1);
            d_reg_wen = 1'b1;
         end
         OPC_OP_IMM: begin
            d_alu     = alu_from_funct(f_funct3, if_insn[30], 1'b0);
            d_fmt     = IMM_I;
            d_reg_wen = 1'b1;
         end
         OPC_LOAD: begin
            d_class   = CLS_LOAD;
            d_fmt     = IMM_I;
            d_reg_wen = 1'b1;
            d_mem_ren = 1'b1;
         end
         OPC_STORE: begin
            d_class   = CLS_STORE;
            d_fmt     = IMM_S;
            d_mem_wen = 1'b1;
         end
         OPC_BRANCH: begin
            d_alu   = ALU_SUB;
            d_class = CLS_BRANCH;
            d_fmt   = IMM_B;
         end
         OPC_JAL: begin
            d_class   = CLS_JAL;
            d_fmt     = IMM_J;
            d_reg_wen = 1'b1;
         end
         OPC_JALR: begin
            d_class   = CLS_JALR;
            d_fmt     = IMM_I;
            d_reg_wen = 1'b1;
         end
         OPC_LUI: begin
            d_alu     = ALU_PASSB;
            d_class   = CLS_LUI;
            d_fmt     = IMM_U;
            d_reg_wen = 1'b1;
         end
         OPC_AUIPC: begin
            d_class   = CLS_AUIPC;
            d_fmt     = IMM_U;
            d_reg_wen = 1'b1;
         end
         default: d_unknown = 1'b1;
      endcase
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign d_illegal = d_unknown;
`else
   assign d_illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_alu_op   <= '0;
         ex_op_class <= '0;
         ex_funct3   <= '0;
         ex_reg_wen  <= 1'b0;
         ex_mem_wen  <= 1'b0;
         ex_mem_ren  <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (xfer) begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_rs1_val  <= rs1_val;
         ex_rs2_val  <= rs2_val;
         ex_imm      <= gen_imm(if_insn, d_fmt);
         ex_rd       <= f_rd;
         ex_alu_op   <= d_alu;
         ex_op_class <= d_class;
         ex_funct3   <= f_funct3;
         // rd=x0 results are architecturally discarded, so never request the write.
         ex_reg_wen  <= d_reg_wen && !d_unknown && (f_rd != 5'd0);
         ex_mem_wen  <= d_mem_wen && !d_unknown;
         ex_mem_ren  <= d_mem_ren && !d_unknown;
         ex_illegal  <= d_illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
// Honours DECODE_ILLEGAL_TRAP_EN when deciding the expected ex_illegal value.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready;
   logic [31:0] if_insn, if_pc;
   logic        flush;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_alu_op;
   logic [2:0]  ex_op_class, ex_funct3;
   logic        ex_reg_wen, ex_mem_wen, ex_mem_ren, ex_illegal;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_insn(if_insn), .if_pc(if_pc),
      .flush(flush),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_op_class(ex_op_class),
      .ex_funct3(ex_funct3), .ex_reg_wen(ex_reg_wen), .ex_mem_wen(ex_mem_wen),
      .ex_mem_ren(ex_mem_ren), .ex_illegal(ex_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one active edge and settle past it; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
      if_valid = v;
      if_insn  = insn;
      if_pc    = pc;
   endtask

   logic exp_illegal;

   initial begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      exp_illegal = 1'b1;
`else
      exp_illegal = 1'b0;
`endif
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
      drive(1'b0, 32'h0, 32'h0);
      step(); step();
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_pc", ex_pc, 32'd0);
      check("rst_imm", ex_imm, 32'd0);
      check("rst_ready", {31'd0, if_ready}, 32'd1);

      // addi x1,x0,5
      rst = 1'b0;
      drive(1'b1, 32'h00500093, 32'h100);
      step();
      check("addi_valid", {31'd0, ex_valid}, 32'd1);
      check("addi_rd", {27'd0, ex_rd}, 32'd1);
      check("addi_imm", ex_imm, 32'd5);
      check("addi_alu", {28'd0, ex_alu_op}, 32'd0);
      check("addi_wen", {31'd0, ex_reg_wen}, 32'd1);
      check("addi_rs1", ex_rs1_val, 32'd0);
      check("addi_pc", ex_pc, 32'h100);

      // add x2,x1,x1 with a same-cycle writeback of x1
      drive(1'b1, 32'h00108133, 32'h104);
      wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
      step();
      wb_wen = 1'b0;
      check("byp_rs1", ex_rs1_val, 32'hDEADBEEF);
      check("byp_rs2", ex_rs2_val, 32'hDEADBEEF);
      check("add_alu", {28'd0, ex_alu_op}, 32'd0);
      check("add_rd", {27'd0, ex_rd}, 32'd2);

      // sw x2,8(x1): x1 now comes from storage, x2 never written
      drive(1'b1, 32'h0020A423, 32'h108);
      step();
      check("sw_imm", ex_imm, 32'd8);
      check("sw_memwen", {31'd0, ex_mem_wen}, 32'd1);
      check("sw_regwen", {31'd0, ex_reg_wen}, 32'd0);
      check("sw_class", {29'd0, ex_op_class}, 32'd2);
      check("sw_rs1", ex_rs1_val, 32'hDEADBEEF);
      check("sw_rs2", ex_rs2_val, 32'd0);

      // Stall with sub x3,x1,x2 pending
      ex_ready = 1'b0;
      drive(1'b1, 32'h402081B3, 32'h10C);
      #1;
      check("stall_ready", {31'd0, if_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_valid", {31'd0, ex_valid}, 32'd1);
         check("stall_pc", ex_pc, 32'h108);
         check("stall_memwen", {31'd0, ex_mem_wen}, 32'd1);
         check("stall_imm", ex_imm, 32'd8);
         check("stall_ready", {31'd0, if_ready}, 32'd0);
      end
      ex_ready = 1'b1;
      #1;
      check("release_ready", {31'd0, if_ready}, 32'd1);
      step();
      check("sub_pc", ex_pc, 32'h10C);
      check("sub_alu", {28'd0, ex_alu_op}, 32'd1);
      check("sub_rd", {27'd0, ex_rd}, 32'd3);

      // srai x4,x1,4 on the very next cycle
      drive(1'b1, 32'h4040D213, 32'h110);
      step();
      check("srai_pc", ex_pc, 32'h110);
      check("srai_alu", {28'd0, ex_alu_op}, 32'd7);
      check("srai_imm", ex_imm, 32'h404);

      // lui x5,0x12345
      drive(1'b1, 32'h123452B7, 32'h114);
      step();
      check("lui_imm", ex_imm, 32'h12345000);
      check("lui_alu", {28'd0, ex_alu_op}, 32'd10);
      check("lui_class", {29'd0, ex_op_class}, 32'd6);

      // beq x1,x2,-4: negative B immediate
      drive(1'b1, 32'hFE208EE3, 32'h118);
      step();
      check("beq_imm", ex_imm, 32'hFFFFFFFC);
      check("beq_alu", {28'd0, ex_alu_op}, 32'd1);
      check("beq_class", {29'd0, ex_op_class}, 32'd3);
      check("beq_regwen", {31'd0, ex_reg_wen}, 32'd0);

      // jal x1,+2048: J immediate bit 11 comes from insn[20]
      drive(1'b1, 32'h001000EF, 32'h11C);
      step();
      check("jal_imm", ex_imm, 32'h800);
      check("jal_class", {29'd0, ex_op_class}, 32'd4);
      check("jal_regwen", {31'd0, ex_reg_wen}, 32'd1);

      // flush while stalled with a valid input
      ex_ready = 1'b0; flush = 1'b1;
      drive(1'b1, 32'h00700313, 32'h200);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      step();
      check("flush_nocap_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_nocap_pc", ex_pc, 32'h11C);

      // write to x0 is discarded
      ex_ready = 1'b1;
      wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
      step();
      wb_wen = 1'b0;
      drive(1'b1, 32'h000003B3, 32'h204);
      step();
      check("x0_rs1", ex_rs1_val, 32'd0);
      check("x0_rs2", ex_rs2_val, 32'd0);
      check("x0_regwen", {31'd0, ex_reg_wen}, 32'd1);

      // x0 write in the same cycle as an x0 read must not bypass
      wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555;
      drive(1'b1, 32'h00000433, 32'h208);
      step();
      wb_wen = 1'b0;
      check("x0_nobyp", ex_rs1_val, 32'd0);

      // addi x0,x0,1: reg_wen suppressed for rd=0
      drive(1'b1, 32'h00100013, 32'h20C);
      step();
      check("rd0_regwen", {31'd0, ex_reg_wen}, 32'd0);

      // unknown opcode
      drive(1'b1, 32'hFFFFFFFF, 32'h210);
      step();
      check("ill_valid", {31'd0, ex_valid}, 32'd1);
      check("ill_flag", {31'd0, ex_illegal}, {31'd0, exp_illegal});
      check("ill_regwen", {31'd0, ex_reg_wen}, 32'd0);
      check("ill_memwen", {31'd0, ex_mem_wen}, 32'd0);
      check("ill_memren", {31'd0, ex_mem_ren}, 32'd0);

      // lw x9,-1(x1): load strobes and all-ones I immediate
      drive(1'b1, 32'hFFF0A483, 32'h214);
      step();
      check("lw_memren", {31'd0, ex_mem_ren}, 32'd1);
      check("lw_imm", ex_imm, 32'hFFFFFFFF);
      check("lw_class", {29'd0, ex_op_class}, 32'd1);

      // drain: no new transfer while execute accepts
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("drain_valid", {31'd0, ex_valid}, 32'd0);

      // reset mid-operation drops the bundle and clears the register file
      drive(1'b1, 32'h00100013, 32'h300);
      step();
      rst = 1'b1;
      step();
      check("midrst_valid", {31'd0, ex_valid}, 32'd0);
      check("midrst_pc", ex_pc, 32'd0);
      rst = 1'b0;
      drive(1'b1, 32'h00008433, 32'h304);
      step();
      check("midrst_x1", ex_rs1_val, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
